acond_sensores: RTL and testbench

// Sensor input conditioning stage, upstream of the warehouse control FSMs.

---
 rtl/acond_sensores.sv | 78 +++++++
 tb/tb_acond_sensores.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/acond_sensores.sv
// rtl/acond_sensores.sv - per-channel two-flop synchroniser and debouncer with edge/glitch pulses
module acond_sensores #(
    parameter int N_SENS     = 2,
    parameter int DEB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SENS-1:0] s_raw,
    output logic [N_SENS-1:0] s_out,
    output logic [N_SENS-1:0] s_rise,
    output logic [N_SENS-1:0] s_fall,
    output logic [N_SENS-1:0] s_glitch
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [N_SENS-1:0] sync1_q, sync2_q;
    logic [N_SENS-1:0] out_q, out_d;
    logic [N_SENS-1:0] rise_q, rise_d;
    logic [N_SENS-1:0] fall_q, fall_d;
    logic [N_SENS-1:0] glitch_q, glitch_d;
    logic [CNT_W-1:0]  cnt_q [N_SENS];
    logic [CNT_W-1:0]  cnt_d [N_SENS];

    // The counter tracks how many consecutive edges sync2 has disagreed with s_out;
    // returning to agreement with a non-zero count means a change was abandoned.
    always_comb begin
        out_d    = out_q;
        rise_d   = '0;
        fall_d   = '0;
        glitch_d = '0;
        for (int i = 0; i < N_SENS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == out_q[i]) begin
                cnt_d[i]    = '0;
                glitch_d[i] = (cnt_q[i] != '0);
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]  = '0;
                out_d[i]  = sync2_q[i];
                rise_d[i] = sync2_q[i];
                fall_d[i] = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            out_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            glitch_q <= '0;
            for (int i = 0; i < N_SENS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= s_raw;
            sync2_q  <= sync1_q;
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
            for (int i = 0; i < N_SENS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign s_out    = out_q;
    assign s_rise   = rise_q;
    assign s_fall   = fall_q;
    assign s_glitch = glitch_q;

endmodule

// File: tb/tb_acond_sensores.sv
// tb/tb_acond_sensores.sv - directed-vector bench for acond_sensores
module tb_acond_sensores;

    logic       clk;
    logic       rst;
    logic [1:0] s_raw;
    logic [1:0] s_out, s_rise, s_fall, s_glitch;

    int checks   = 0;
    int failures = 0;

    acond_sensores #(.N_SENS(2), .DEB_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_raw    (s_raw),
        .s_out    (s_out),
        .s_rise   (s_rise),
        .s_fall   (s_fall),
        .s_glitch (s_glitch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; outputs are sampled 1 time unit after the edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int glitch1_cnt;
    int glitch0_cnt;
    int rise_seen;
    int fall_seen;

    initial begin
        rst   = 1'b1;
        s_raw = 2'b11;

        // 1: reset with inputs high, then release
        tick(3);
        check("rst_out",    8'(s_out),    8'h0);
        check("rst_rise",   8'(s_rise),   8'h0);
        check("rst_fall",   8'(s_fall),   8'h0);
        check("rst_glitch", 8'(s_glitch), 8'h0);
        rst = 1'b0;
        tick(5);
        check("rel_out_e5",  8'(s_out),  8'h0);
        check("rel_rise_e5", 8'(s_rise), 8'h0);
        tick(1);
        check("rel_out_e6",  8'(s_out),  8'h3);
        check("rel_rise_e6", 8'(s_rise), 8'h3);
        s_raw = 2'b00;
        tick(6);
        check("back0_out",  8'(s_out),  8'h0);
        check("back0_fall", 8'(s_fall), 8'h3);
        tick(2);

        // 2: clean press on channel 0
        s_raw = 2'b01;
        tick(5);
        check("press_out_e5",  8'(s_out),  8'h0);
        check("press_rise_e5", 8'(s_rise), 8'h0);
        tick(1);
        check("press_out_e6",    8'(s_out),    8'h1);
        check("press_rise_e6",   8'(s_rise),   8'h1);
        check("press_glitch_e6", 8'(s_glitch), 8'h0);
        tick(1);
        check("press_rise_e7", 8'(s_rise), 8'h0);
        check("press_out_e7",  8'(s_out),  8'h1);
        tick(3);

        // 3: two-cycle glitch on channel 1
        s_raw = 2'b11;
        tick(2);
        s_raw = 2'b01;
        glitch1_cnt = 0;
        rise_seen   = 0;
        for (int k = 3; k <= 12; k++) begin
            tick(1);
            if (s_glitch[1]) glitch1_cnt++;
            if (s_rise != 2'b00) rise_seen++;
            if (k == 5) check("glitch_at_e5", 8'(s_glitch), 8'h2);
        end
        check("glitch_count", 8'(glitch1_cnt), 8'd1);
        check("glitch_norise", 8'(rise_seen), 8'd0);
        check("glitch_out",   8'(s_out), 8'h1);

        // 4: release channel 0
        s_raw = 2'b00;
        tick(5);
        check("rel0_fall_e5", 8'(s_fall), 8'h0);
        check("rel0_out_e5",  8'(s_out),  8'h1);
        tick(1);
        check("rel0_fall_e6", 8'(s_fall), 8'h1);
        check("rel0_out_e6",  8'(s_out),  8'h0);
        tick(2);

        // 5: simultaneous rise, then channel 1 falls alone
        s_raw = 2'b11;
        tick(6);
        check("sim_rise", 8'(s_rise), 8'h3);
        check("sim_out",  8'(s_out),  8'h3);
        tick(2);
        s_raw = 2'b01;
        tick(6);
        check("sim_fall1", 8'(s_fall), 8'h2);
        check("sim_rise0", 8'(s_rise), 8'h0);
        check("sim_out01", 8'(s_out),  8'h1);
        tick(2);

        // toggling every cycle never changes s_out but keeps glitching
        glitch0_cnt = 0;
        fall_seen   = 0;
        for (int k = 0; k < 12; k++) begin
            s_raw[0] = k[0];
            tick(1);
            if (s_glitch[0]) glitch0_cnt++;
            if (s_fall != 2'b00) fall_seen++;
        end
        check("tog_glitches", 8'(glitch0_cnt >= 4), 8'd1);
        check("tog_nofall",   8'(fall_seen), 8'd0);
        check("tog_out",      8'(s_out), 8'h1);

        // return both channels low
        s_raw = 2'b00;
        tick(10);
        check("idle_out", 8'(s_out), 8'h0);

        // 6: reset mid-debounce
        s_raw = 2'b01;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_out",  8'(s_out),  8'h0);
        check("mid_rst_rise", 8'(s_rise), 8'h0);
        tick(5);
        check("post_rst_rise_e5", 8'(s_rise), 8'h0);
        check("post_rst_out_e5",  8'(s_out),  8'h0);
        tick(1);
        check("post_rst_rise_e6", 8'(s_rise), 8'h1);
        check("post_rst_out_e6",  8'(s_out),  8'h1);
        tick(5);
        check("hold_no_pulse", 8'({s_rise, s_fall, s_glitch}), 8'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
